// File: rtl/uart_rx_key.sv
// UART 8N1 receiver for the typing-test datapath: deserialises host keystrokes,
// pulses rx_valid per good frame and keeps a sticky key_pressed flag for the controller.
module uart_rx_key #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clr_pressed,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       key_pressed,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_d;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic [7:0]       rx_byte_d;
    logic             rx_valid_d, frame_err_d, key_pressed_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and datapath decode; all sample points sit mid-bit
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CNT_W'(1);
        bit_idx_d   = bit_idx;
        shift_d     = shift;
        rx_byte_d   = rx_byte;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx] = rx_s;
                    bit_idx_d        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_byte_d  = shift;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // A key arriving in the same cycle as a clear must not be lost
        key_pressed_d = rx_valid | (key_pressed & ~clr_pressed);
    end

    // Synchroniser, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            key_pressed <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            cnt         <= cnt_d;
            bit_idx     <= bit_idx_d;
            shift       <= shift_d;
            rx_byte     <= rx_byte_d;
            rx_valid    <= rx_valid_d;
            frame_err   <= frame_err_d;
            key_pressed <= key_pressed_d;
            rx_busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_key.sv
// Bench for uart_rx_key: frame-level event model (expected byte/error and arrival
// window per frame) checked every cycle, plus literal expectations per scenario.
module tb_uart_rx_key;

    localparam int unsigned CPB = 16;
    localparam int          MID = 2 + (int'(CPB) * 19) / 2;

    logic       clk = 1'b0;
    logic       rst, rx, clr_pressed;
    logic [7:0] rx_byte;
    logic       rx_valid, key_pressed, frame_err, rx_busy;

    uart_rx_key #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clr_pressed(clr_pressed),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .key_pressed(key_pressed),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        int         lo;
        int         hi;
    } evt_t;

    evt_t       exp_q[$];
    int         tests = 0, fails = 0, cyc = 0, n_valid = 0, n_ferr = 0;
    logic [7:0] last_byte_m = 8'h00;
    logic       key_m = 1'b0;
    bit         valid_seen = 1'b0, armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sticky flag model: a delivered key sets it, a clear request drops it, set wins
    always @(posedge clk) begin
        if (rst) key_m <= 1'b0;
        else     key_m <= valid_seen | (key_m & ~clr_pressed);
    end

    // Per-cycle comparison against the frame event model
    always @(negedge clk) begin
        valid_seen = 1'b0;
        if (armed) begin
            check("valid_ferr_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (rx_valid === 1'b1) begin
                n_valid++;
                if (exp_q.size() > 0 && !exp_q[0].is_err && cyc >= exp_q[0].lo && cyc <= exp_q[0].hi) begin
                    last_byte_m = exp_q[0].b;
                    valid_seen  = 1'b1;
                    void'(exp_q.pop_front());
                end else begin
                    check("unexpected_rx_valid", 32'd1, 32'd0);
                end
            end
            if (frame_err === 1'b1) begin
                n_ferr++;
                if (exp_q.size() > 0 && exp_q[0].is_err && cyc >= exp_q[0].lo && cyc <= exp_q[0].hi)
                    void'(exp_q.pop_front());
                else
                    check("unexpected_frame_err", 32'd1, 32'd0);
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                check(exp_q[0].is_err ? "missed_frame_err" : "missed_rx_valid", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            check("rx_byte", 32'(rx_byte), 32'(last_byte_m));
            check("key_pressed", 32'(key_pressed), 32'(key_m));
            if (rst) begin
                last_byte_m = 8'h00;
                exp_q.delete();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        evt_t e;
        rx       = 1'b0;
        e.is_err = !stop_bit;
        e.b      = b;
        e.lo     = cyc + MID - 3;
        e.hi     = cyc + MID + 3;
        exp_q.push_back(e);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, nf;
        bit found;
        rst = 1'b1;
        rx = 1'b1;
        clr_pressed = 1'b0;
        tick(3);
        rst = 1'b0;
        armed = 1'b1;

        // 1: reset state and long idle
        check("reset_rx_busy", 32'(rx_busy), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        nv = n_valid; nf = n_ferr;
        tick(200);
        check("idle_rx_byte", 32'(rx_byte), 32'h00);
        check("idle_rx_busy", 32'(rx_busy), 32'd0);
        check("idle_key_pressed", 32'(key_pressed), 32'd0);
        check("idle_pulses", 32'(n_valid - nv + n_ferr - nf), 32'd0);

        // 2: single clean frame
        nv = n_valid; nf = n_ferr;
        send_frame(8'h41, 1'b1);
        tick(4);
        check("t2_valid_count", 32'(n_valid - nv), 32'd1);
        check("t2_ferr_count", 32'(n_ferr - nf), 32'd0);
        check("t2_rx_byte", 32'(rx_byte), 32'h41);
        check("t2_key_pressed", 32'(key_pressed), 32'd1);

        // 3: short glitch is rejected
        nv = n_valid; nf = n_ferr;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("t3_pulses", 32'(n_valid - nv + n_ferr - nf), 32'd0);
        check("t3_rx_byte", 32'(rx_byte), 32'h41);
        check("t3_rx_busy", 32'(rx_busy), 32'd0);

        // 4: bad stop bit, held break, then recovery
        nv = n_valid; nf = n_ferr;
        send_frame(8'h55, 1'b0);
        tick(100);
        check("t4_ferr_count", 32'(n_ferr - nf), 32'd1);
        check("t4_valid_count", 32'(n_valid - nv), 32'd0);
        check("t4_busy_in_break", 32'(rx_busy), 32'd1);
        check("t4_rx_byte_kept", 32'(rx_byte), 32'h41);
        rx = 1'b1;
        tick(6);
        check("t4_busy_released", 32'(rx_busy), 32'd0);
        send_frame(8'h7A, 1'b1);
        tick(4);
        check("t4_rx_byte_7a", 32'(rx_byte), 32'h7A);
        check("t4_valid_after", 32'(n_valid - nv), 32'd1);

        // 5: back-to-back frames
        nv = n_valid; nf = n_ferr;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(4);
        check("t5_valid_count", 32'(n_valid - nv), 32'd2);
        check("t5_ferr_count", 32'(n_ferr - nf), 32'd0);
        check("t5_rx_byte", 32'(rx_byte), 32'hFF);

        // 6a: clear coincident with a new key keeps the flag
        found = 1'b0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int i = 0; i < 300 && !found; i++) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) found = 1'b1;
                end
                if (found) begin
                    clr_pressed = 1'b1;
                    @(negedge clk);
                    clr_pressed = 1'b0;
                end
            end
        join
        check("t6_clr_aligned", 32'(found), 32'd1);
        tick(2);
        check("t6_key_set_wins", 32'(key_pressed), 32'd1);
        check("t6_rx_byte", 32'(rx_byte), 32'h5A);

        // 6b: clear alone
        clr_pressed = 1'b1;
        tick(1);
        clr_pressed = 1'b0;
        check("t6_key_cleared", 32'(key_pressed), 32'd0);

        // 6c: reset in the middle of a 0x33 frame, then a clean 0x33
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            tick(CPB);
        end
        tick(5);
        rx = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_rx_byte", 32'(rx_byte), 32'h00);
        check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_frame_err", 32'(frame_err), 32'd0);
        check("t6_rst_key", 32'(key_pressed), 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        tick(40);
        nv = n_valid;
        send_frame(8'h33, 1'b1);
        tick(4);
        check("t6_post_rst_valid", 32'(n_valid - nv), 32'd1);
        check("t6_post_rst_byte", 32'(rx_byte), 32'h33);
        check("t6_post_rst_key", 32'(key_pressed), 32'd1);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
